// File: rtl/audio_pkg.sv
// Shared constants and types for the I2S serializer slice.
// AUD_LEFT_JUSTIFIED_EN selects left-justified framing instead of I2S.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned CH_LEFT  = 0;
  localparam int unsigned CH_RIGHT = 1;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // Slot positions (bit_cnt mod SLOT_BITS) carrying data bits, and the commit point
`ifdef AUD_LEFT_JUSTIFIED_EN
  localparam int unsigned DAT_FIRST  = 0;
`else
  localparam int unsigned DAT_FIRST  = 1;
`endif
  localparam int unsigned DAT_LAST   = DAT_FIRST + SAMPLE_W - 1;
  localparam int unsigned COMMIT_POS = DAT_LAST + 1;

  typedef enum logic {
    LINK_PRIME,
    LINK_RUN
  } link_state_t;

endpackage

// File: rtl/aud_bclk_gen.sv
// Bit-clock divider and frame bit counter; bit_cnt and LRCK advance on BCLK falls.
// rise/fall are high in the clk cycle whose active edge performs that BCLK transition.
module aud_bclk_gen #(
  parameter int unsigned BCLK_HALF = 4,
  parameter int unsigned SLOT_BITS = 32,
  localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS),
  localparam int unsigned DIV_W = $clog2(BCLK_HALF)
) (
  input  logic             clk,
  input  logic             reset,
  output logic             aud_bclk,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] bit_cnt_nxt,
  output logic             aud_daclrck
);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  always_comb begin
    wrap        = (div_cnt == DIV_W'(BCLK_HALF - 1));
    rise        = wrap & ~aud_bclk;
    fall        = wrap & aud_bclk;
    bit_cnt_nxt = (bit_cnt == CNT_W'(2 * SLOT_BITS - 1)) ? '0 : bit_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt     <= '0;
      aud_bclk    <= 1'b0;
      bit_cnt     <= '0;
      aud_daclrck <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + DIV_W'(1);
      if (wrap) begin
        aud_bclk <= ~aud_bclk;
      end
      if (fall) begin
        bit_cnt     <= bit_cnt_nxt;
        aud_daclrck <= (bit_cnt_nxt >= CNT_W'(SLOT_BITS));
      end
    end
  end

endmodule

// File: rtl/audio_i2s_serializer.sv
// Master-mode I2S link: sample requests, DAC serialiser and ADC deserialiser.
// Define AUD_LEFT_JUSTIFIED_EN for left-justified framing (no one-bit delay).
module audio_i2s_serializer
  import audio_pkg::*;
#(
  parameter int unsigned BCLK_HALF = 4,
  parameter int unsigned SLOT_BITS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  sample_req,
  input  logic [15:0] audio_in,
  output logic [1:0]  sample_end,
  output logic [15:0] adc_data,
  output logic        aud_bclk,
  output logic        aud_daclrck,
  output logic        aud_adclrck,
  output logic        aud_dacdat,
  input  logic        aud_adcdat
);

  localparam int unsigned CNT_W = $clog2(2 * SLOT_BITS);

  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] bit_cnt_nxt;
  logic [CNT_W-1:0] slot_cur;
  logic [CNT_W-1:0] slot_nxt;
  logic             dac_win;
  logic             adc_win;
  logic [1:0]       req_now;
  link_state_t      state;
  link_state_t      state_nxt;
  sample_t          dac_sr;
  sample_t          adc_sr;

  aud_bclk_gen #(
    .BCLK_HALF(BCLK_HALF),
    .SLOT_BITS(SLOT_BITS)
  ) u_bclk_gen (
    .clk        (clk),
    .reset      (reset),
    .aud_bclk   (aud_bclk),
    .rise       (rise),
    .fall       (fall),
    .bit_cnt    (bit_cnt),
    .bit_cnt_nxt(bit_cnt_nxt),
    .aud_daclrck(aud_daclrck)
  );

  always_comb begin
    aud_adclrck = aud_daclrck;
    slot_cur = (bit_cnt >= CNT_W'(SLOT_BITS)) ? bit_cnt - CNT_W'(SLOT_BITS) : bit_cnt;
    slot_nxt = (bit_cnt_nxt >= CNT_W'(SLOT_BITS)) ? bit_cnt_nxt - CNT_W'(SLOT_BITS)
                                                   : bit_cnt_nxt;
    // Unsigned wrap makes positions below DAT_FIRST fall outside the window
    dac_win  = (slot_nxt - CNT_W'(DAT_FIRST)) < CNT_W'(SAMPLE_W);
    adc_win  = (slot_cur - CNT_W'(DAT_FIRST)) < CNT_W'(SAMPLE_W);
  end

  // The right-slot request is held off until the first frame wrap, so the frame
  // following reset carries zeros in both slots.
  always_comb begin
    state_nxt = state;
    req_now   = '0;
    if (fall && bit_cnt_nxt == '0) begin
      req_now[CH_LEFT] = 1'b1;
      state_nxt        = LINK_RUN;
    end
    if (fall && bit_cnt_nxt == CNT_W'(SLOT_BITS) && state == LINK_RUN) begin
      req_now[CH_RIGHT] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LINK_PRIME;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef AUD_LEFT_JUSTIFIED_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      dac_sr     <= '0;
      aud_dacdat <= 1'b0;
    end else if (|req_now) begin
      // MSB leaves on the LRCK edge itself, straight from the mixer bus
      aud_dacdat <= audio_in[15];
      dac_sr     <= {audio_in[14:0], 1'b0};
    end else if (fall) begin
      if (dac_win) begin
        {aud_dacdat, dac_sr} <= {dac_sr, 1'b0};
      end else begin
        aud_dacdat <= 1'b0;
      end
    end
  end
`else
  logic pending;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending    <= 1'b0;
      dac_sr     <= '0;
      aud_dacdat <= 1'b0;
    end else begin
      if (|req_now) begin
        pending <= 1'b1;
      end else if (rise && pending) begin
        dac_sr  <= audio_in;
        pending <= 1'b0;
      end
      if (fall) begin
        if (dac_win) begin
          {aud_dacdat, dac_sr} <= {dac_sr, 1'b0};
        end else begin
          aud_dacdat <= 1'b0;
        end
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sample_req <= '0;
      sample_end <= '0;
      adc_sr     <= '0;
      adc_data   <= '0;
    end else begin
      sample_req <= req_now;
      sample_end <= '0;
      if (rise && adc_win) begin
        adc_sr <= {adc_sr[14:0], aud_adcdat};
      end
      if (fall && slot_nxt == CNT_W'(COMMIT_POS)) begin
        adc_data <= adc_sr;
        if (aud_daclrck) begin
          sample_end[CH_RIGHT] <= 1'b1;
        end else begin
          sample_end[CH_LEFT] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_i2s_serializer.sv
// Directed bench: cycle-timed model of BCLK/LRCK/requests, DAC word scoreboard
// with ADC loopback, and a mid-word reset.
module tb_audio_i2s_serializer;

  localparam int BH = 4;
  localparam int SB = 32;
  localparam int HALF_FRAME = SB * 2 * BH;
`ifdef AUD_LEFT_JUSTIFIED_EN
  localparam int FIRST = 0;
`else
  localparam int FIRST = 1;
`endif
  localparam int COMMIT = FIRST + 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sample_req;
  logic [15:0] audio_in;
  logic [1:0]  sample_end;
  logic [15:0] adc_data;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_adclrck;
  logic        aud_dacdat;
  logic        aud_adcdat;

  assign aud_adcdat = aud_dacdat;

  audio_i2s_serializer #(
    .BCLK_HALF(BH),
    .SLOT_BITS(SB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sample_req (sample_req),
    .audio_in   (audio_in),
    .sample_end (sample_end),
    .adc_data   (adc_data),
    .aud_bclk   (aud_bclk),
    .aud_daclrck(aud_daclrck),
    .aud_adclrck(aud_adclrck),
    .aud_dacdat (aud_dacdat),
    .aud_adcdat (aud_adcdat)
  );

  always #5 clk = ~clk;

  int          cyc;
  int          n_cmp;
  int          n_err;
  int          idx;
  logic [15:0] words [8];
  logic [15:0] dac_q [$];
  logic [15:0] adc_q [$];
  logic [15:0] cur_word;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc      = 0;
    idx      = 0;
    cur_word = '0;
    dac_q.delete();
    adc_q.delete();
`ifdef AUD_LEFT_JUSTIFIED_EN
    audio_in = words[0];
`else
    audio_in = 16'h1234;
`endif
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    check("rst_bclk", {15'd0, aud_bclk}, 16'd0);
    check("rst_lrck", {14'd0, aud_adclrck, aud_daclrck}, 16'd0);
    check("rst_req", {14'd0, sample_req}, 16'd0);
    check("rst_end", {14'd0, sample_end}, 16'd0);
    check("rst_adc", adc_data, 16'd0);
    check("rst_dacdat", {15'd0, aud_dacdat}, 16'd0);
  endtask

  task automatic tick();
    int         bm;
    int         slot;
    logic       eb;
    logic       el;
    logic [1:0] er;
    logic [1:0] ee;
    logic [15:0] ea;
    @(negedge clk);
    cyc++;
    bm = (cyc / (2 * BH)) % (2 * SB);
    slot = bm % SB;
    eb = ((cyc / BH) % 2) == 1;
    el = bm >= SB;
    er = 2'b00;
    if (cyc > 0 && cyc % HALF_FRAME == 0) begin
      if (cyc % (2 * HALF_FRAME) == 0) er = 2'b01;
      else if (cyc > 2 * HALF_FRAME) er = 2'b10;
    end
    ee = 2'b00;
    if (cyc % HALF_FRAME == COMMIT * 2 * BH) begin
      ee = ((cyc % (2 * HALF_FRAME)) >= HALF_FRAME) ? 2'b10 : 2'b01;
    end
    check("bclk", {15'd0, aud_bclk}, {15'd0, eb});
    check("daclrck", {15'd0, aud_daclrck}, {15'd0, el});
    check("adclrck", {15'd0, aud_adclrck}, {15'd0, el});
    check("sample_req", {14'd0, sample_req}, {14'd0, er});
    check("sample_end", {14'd0, sample_end}, {14'd0, ee});
    if (ee != 2'b00) begin
      ea = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
      check("adc_data", adc_data, ea);
    end
    if (cyc % (2 * BH) == BH) begin
      if (slot == FIRST) begin
        cur_word = (dac_q.size() > 0) ? dac_q.pop_front() : 16'h0000;
        adc_q.push_back(cur_word);
      end
      if (slot >= FIRST && slot < FIRST + 16)
        check("dacdat", {15'd0, aud_dacdat}, {15'd0, cur_word[15 - (slot - FIRST)]});
      else
        check("dacdat_idle", {15'd0, aud_dacdat}, 16'd0);
    end
    // Mixer model reacting to the DUT's requests
    if (sample_req != 2'b00) begin
`ifdef AUD_LEFT_JUSTIFIED_EN
      dac_q.push_back(words[idx]);
      idx = (idx + 1) % 8;
      audio_in = words[idx];
`else
      audio_in = words[idx];
      dac_q.push_back(words[idx]);
      idx = (idx + 1) % 8;
`endif
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    words[0] = 16'h8001; words[1] = 16'hA5F0; words[2] = 16'h7FFE; words[3] = 16'h0001;
    words[4] = 16'hFFFF; words[5] = 16'h0000; words[6] = 16'h5A5A; words[7] = 16'hC3C3;
    reset = 1'b1;
    model_reset();
    repeat (5) rst_cycle();
    reset = 1'b0;
    model_reset();
    // Three full frames, then stop in the left slot at slot_pos 8
    repeat (3 * 2 * HALF_FRAME + 8 * 2 * BH + 2) tick();
    reset = 1'b1;
    repeat (4) rst_cycle();
    reset = 1'b0;
    model_reset();
    repeat (2 * 2 * HALF_FRAME + 200) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
